// File: rtl/lsu_sequencer_if.sv
// Data-memory port bundle between the load/store sequencer and memory.
//   master (sequencer): drives mem_req, mem_we, mem_addr, mem_be, mem_wdata;
//                       samples mem_ready, mem_rdata.
//   slave  (memory)   : the mirror image.
// mem_ready both accepts and completes a request in the same cycle;
// mem_rdata is meaningful only when mem_ready && !mem_we.
interface lsu_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer between the execute stage and the data
// memory port. One memory instruction is handled at a time: it is classified
// in IDLE, issued in REQ (held until mem_ready or timeout) and reported in a
// one-cycle DONE strobe.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid             execute stage presents a memory instruction
//   is_load, is_store     decoder load-select / MemWrite
//   funct3                access type (b, h, w, bu, hu)
//   addr, wdata           byte address and store data
//   stall                 combinational pipeline freeze
//   rsp_valid             one-cycle result/fault strobe
//   rdata                 extended load data (0 for stores and faults)
//   fault                 0 none, 1 misaligned, 2 illegal, 3 timeout
//   mem                   data-memory port (lsu_sequencer_if.master)
// Parameter TIMEOUT_CYCLES (1-255): REQ cycles without mem_ready before abort.
module lsu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [31:0]           rdata,
  output logic [1:0]            fault,
  lsu_sequencer_if.master       mem
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] FAULT_NONE  = 2'd0;
  localparam logic [1:0] FAULT_ALIGN = 2'd1;
  localparam logic [1:0] FAULT_ILL   = 2'd2;
  localparam logic [1:0] FAULT_TMO   = 2'd3;

  state_t      state_r, state_nxt_s;
  logic [7:0]  cnt_r, cnt_nxt_s;

  logic        accept_s, illegal_s, misaligned_s, load_fields_s;
  logic        mem_req_nxt_s, rsp_valid_nxt_s;
  logic [31:0] rdata_nxt_s;
  logic [1:0]  fault_nxt_s;

  logic        mem_req_r, mem_we_r, rsp_valid_r;
  logic [31:0] mem_addr_r, mem_wdata_r, rdata_r;
  logic [3:0]  mem_be_r;
  logic [1:0]  fault_r;
  logic [2:0]  f3_r;
  logic [1:0]  lane_r;

  // Byte enables: funct3[1:0] encodes size for both signed and unsigned forms.
  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'd0:    be = 4'b0001 << a;
      2'd1:    be = 4'b0011 << {a[1], 1'b0};
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane so memory can pick any byte/half.
  function automatic logic [31:0] lane_replicate(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      2'd2:    r = d;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Select the addressed byte/half of the read word and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd2:    r = word;
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Request classification; illegal wins over misaligned further down.
  always_comb begin
    accept_s     = req_valid && (is_load || is_store);
    illegal_s    = (is_load && is_store) ||
                   (is_load && ((funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7))) ||
                   (is_store && (funct3 > 3'd2));
    misaligned_s = ((funct3[1:0] == 2'd1) && addr[0]) ||
                   ((funct3 == 3'd2) && (addr[1:0] != 2'b00));
  end

  // State register and REQ wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; mem_ready beats the timeout on the last counted cycle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = 8'd0;
        if (accept_s) begin
          state_nxt_s = (illegal_s || misaligned_s) ? ST_DONE : ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem.mem_ready) begin
          state_nxt_s = ST_DONE;
          cnt_nxt_s   = 8'd0;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
          cnt_nxt_s   = 8'd0;
        end else begin
          state_nxt_s = ST_REQ;
          cnt_nxt_s   = cnt_r + 8'd1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 8'd0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // Output logic: combinational stall plus next values for registered outputs.
  always_comb begin
    // rst_n gating keeps stall low while reset is held, even with req_valid up.
    stall           = rst_n && (((state_r == ST_IDLE) && accept_s) || (state_r == ST_REQ));
    mem_req_nxt_s   = (state_nxt_s == ST_REQ);
    rsp_valid_nxt_s = (state_nxt_s == ST_DONE);
    rdata_nxt_s     = 32'd0;
    fault_nxt_s     = FAULT_NONE;
    load_fields_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (illegal_s) begin
            fault_nxt_s = FAULT_ILL;
          end else if (misaligned_s) begin
            fault_nxt_s = FAULT_ALIGN;
          end else begin
            load_fields_s = 1'b1;
          end
        end else begin
          fault_nxt_s = FAULT_NONE;
        end
      end
      ST_REQ: begin
        if (mem.mem_ready) begin
          if (!mem_we_r) begin
            rdata_nxt_s = load_extend(f3_r, lane_r, mem.mem_rdata);
          end else begin
            rdata_nxt_s = 32'd0;
          end
        end else if (cnt_r == CNT_LAST) begin
          fault_nxt_s = FAULT_TMO;
        end else begin
          fault_nxt_s = FAULT_NONE;
        end
      end
      ST_DONE: begin
        fault_nxt_s = FAULT_NONE;
      end
      default: begin
        fault_nxt_s = FAULT_NONE;
      end
    endcase
  end

  // Registered outputs and the request fields held stable through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_be_r    <= 4'd0;
      mem_wdata_r <= 32'd0;
      rsp_valid_r <= 1'b0;
      rdata_r     <= 32'd0;
      fault_r     <= 2'd0;
      f3_r        <= 3'd0;
      lane_r      <= 2'd0;
    end else begin
      mem_req_r   <= mem_req_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rdata_r     <= rdata_nxt_s;
      fault_r     <= fault_nxt_s;
      if (load_fields_s) begin
        mem_we_r    <= is_store;
        mem_addr_r  <= {addr[31:2], 2'b00};
        mem_be_r    <= byte_enables(funct3, addr[1:0]);
        mem_wdata_r <= lane_replicate(funct3, wdata);
        f3_r        <= funct3;
        lane_r      <= addr[1:0];
      end else begin
        mem_we_r    <= mem_we_r;
        mem_addr_r  <= mem_addr_r;
        mem_be_r    <= mem_be_r;
        mem_wdata_r <= mem_wdata_r;
        f3_r        <= f3_r;
        lane_r      <= lane_r;
      end
    end
  end

  assign mem.mem_req   = mem_req_r;
  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_be    = mem_be_r;
  assign mem.mem_wdata = mem_wdata_r;
  assign rsp_valid     = rsp_valid_r;
  assign rdata         = rdata_r;
  assign fault         = fault_r;

endmodule
